// File: rtl/tdd_frame_timer.sv
// tdd_frame_timer: sync-armed frame counter with optional startup delay and burst limit; TDD_FRAME_INDEX_EN adds tdd_frame_index
module tdd_frame_timer #(
    parameter int REGISTER_WIDTH    = 32,
    parameter int BURST_COUNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tdd_enable,
    input  logic                         tdd_sync,
    input  logic                         tdd_sync_rst,
    input  logic [REGISTER_WIDTH-1:0]    asy_tdd_frame_length,
    input  logic [REGISTER_WIDTH-1:0]    asy_tdd_startup_delay,
    input  logic [BURST_COUNT_WIDTH-1:0] asy_tdd_burst_count,
    output logic [1:0]                   tdd_cstate,
    output logic [REGISTER_WIDTH-1:0]    tdd_counter,
    output logic                         tdd_endof_frame,
    output logic                         tdd_frame_start,
    output logic                         tdd_burst_done,
    output logic [BURST_COUNT_WIDTH-1:0] tdd_frame_index
);
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, WAITING = 2'd2, RUNNING = 2'd3;
    logic [REGISTER_WIDTH-1:0]    frame_len, start_dly, len_eff;
    logic [BURST_COUNT_WIDTH-1:0] burst_cfg, burst_cnt;
    logic                         sync_go;
    always_comb begin
        len_eff         = frame_len == '0 ? REGISTER_WIDTH'(1) : frame_len;
        tdd_frame_start = tdd_cstate == RUNNING && tdd_counter == '0;
        tdd_endof_frame = tdd_cstate == RUNNING && tdd_counter == len_eff - REGISTER_WIDTH'(1);
        sync_go         = tdd_sync && (tdd_cstate == ARMED || (tdd_cstate[1] && tdd_sync_rst));
        tdd_burst_done  = tdd_endof_frame && burst_cnt == BURST_COUNT_WIDTH'(1) && !sync_go;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            tdd_cstate  <= IDLE;
            tdd_counter <= '0;
            burst_cnt   <= '0;
            frame_len   <= '0;
            start_dly   <= '0;
            burst_cfg   <= '0;
        end else begin
            if (tdd_cstate == IDLE) begin
                frame_len <= asy_tdd_frame_length;
                start_dly <= asy_tdd_startup_delay;
                burst_cfg <= asy_tdd_burst_count;
            end
            if (!tdd_enable) begin
                tdd_cstate  <= IDLE;
                tdd_counter <= '0;
                burst_cnt   <= '0;
            end else if (sync_go) begin
                tdd_cstate  <= start_dly == '0 ? RUNNING : WAITING;
                tdd_counter <= '0;
                burst_cnt   <= burst_cfg;
            end else if (tdd_cstate == IDLE) begin
                tdd_cstate <= ARMED;
            end else if (tdd_cstate == WAITING) begin
                if (tdd_counter == start_dly - REGISTER_WIDTH'(1)) begin
                    tdd_cstate  <= RUNNING;
                    tdd_counter <= '0;
                end else begin
                    tdd_counter <= tdd_counter + REGISTER_WIDTH'(1);
                end
            end else if (tdd_cstate == RUNNING) begin
                if (tdd_endof_frame) begin
                    tdd_counter <= '0;
                    if (burst_cnt != '0) burst_cnt <= burst_cnt - BURST_COUNT_WIDTH'(1);
                    if (burst_cnt == BURST_COUNT_WIDTH'(1)) tdd_cstate <= ARMED;
                end else begin
                    tdd_counter <= tdd_counter + REGISTER_WIDTH'(1);
                end
            end
        end
    end
`ifdef TDD_FRAME_INDEX_EN
    always_ff @(posedge clk) begin
        if (rst || !tdd_enable || sync_go) tdd_frame_index <= '0;
        else if (tdd_endof_frame) tdd_frame_index <= tdd_frame_index + BURST_COUNT_WIDTH'(1);
    end
`else
    assign tdd_frame_index = '0;
`endif
endmodule

// File: tb/tb_tdd_frame_timer.sv
// tb_tdd_frame_timer: random stimulus against an arithmetic sync-anchored model, checked through a scoreboard queue
module tb_tdd_frame_timer;
    logic        clk = 0;
    logic        rst = 1, en = 0, sync = 0, sync_rst = 0;
    logic [31:0] len_in = 0, dly_in = 0, bst_in = 0;
    logic [1:0]  cstate;
    logic [31:0] counter, frame_index;
    logic        eof, fstart, bdone;

    tdd_frame_timer dut (
        .clk(clk), .rst(rst), .tdd_enable(en), .tdd_sync(sync), .tdd_sync_rst(sync_rst),
        .asy_tdd_frame_length(len_in), .asy_tdd_startup_delay(dly_in), .asy_tdd_burst_count(bst_in),
        .tdd_cstate(cstate), .tdd_counter(counter), .tdd_endof_frame(eof),
        .tdd_frame_start(fstart), .tdd_burst_done(bdone), .tdd_frame_index(frame_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] cnt;
        logic        eof, fs, bd;
        logic [31:0] idx;
    } exp_t;

    exp_t   sbq[$];
    int     total = 0, bad = 0;
    int     m_mode = 0;
    longint t = 0, m_s = 0;
    longint c_len = 0, c_dly = 0, c_bst = 0;

    // Expected outputs at cycle t: everything follows from the cycle of the last accepted sync.
    function automatic exp_t eval(input logic s_in, input logic sr_in);
        exp_t e;
        longint k, j, f, c, l;
        e.st = 0; e.cnt = 0; e.eof = 0; e.fs = 0; e.bd = 0; e.idx = 0;
        if (m_mode == 1) e.st = 1;
        else if (m_mode == 2) begin
            k = t - m_s - 1;
            if (k < c_dly) begin
                e.st = 2;
                e.cnt = 32'(k);
            end else begin
                j = k - c_dly;
                l = c_len == 0 ? 1 : c_len;
                f = j / l;
                c = j % l;
                if (c_bst != 0 && f >= c_bst) begin
                    e.st = 1;
                    e.idx = 32'(c_bst);
                end else begin
                    e.st = 3;
                    e.cnt = 32'(c);
                    e.fs = c == 0;
                    e.eof = c == l - 1;
                    e.bd = e.eof && c_bst != 0 && f == c_bst - 1 && !(s_in && sr_in);
                    e.idx = 32'(f);
                end
            end
        end
`ifndef TDD_FRAME_INDEX_EN
        e.idx = 0;
`endif
        return e;
    endfunction

    task automatic step(input exp_t e);
        if (rst) begin
            m_mode = 0;
            c_len = 0; c_dly = 0; c_bst = 0;
        end else begin
            if (e.st == 0) begin
                c_len = len_in; c_dly = dly_in; c_bst = bst_in;
            end
            if (!en) m_mode = 0;
            else if (e.st == 0) m_mode = 1;
            else if (sync && (e.st == 1 || sync_rst)) begin
                m_mode = 2;
                m_s = t;
            end
        end
        t++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("cstate", 32'(cstate), 32'(e.st));
            chk("counter", counter, e.cnt);
            chk("endof_frame", 32'(eof), 32'(e.eof));
            chk("frame_start", 32'(fstart), 32'(e.fs));
            chk("burst_done", 32'(bdone), 32'(e.bd));
            chk("frame_index", frame_index, e.idx);
        end
    end

    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5000; i++) begin
            rst = $urandom_range(0, 399) == 0;
            if (en) en = $urandom_range(0, 59) != 0;
            else en = $urandom_range(0, 2) == 0;
            sync = $urandom_range(0, 9) == 0;
            if ($urandom_range(0, 49) == 0) sync_rst = ~sync_rst;
            len_in = $urandom_range(0, 6);
            dly_in = $urandom_range(0, 4);
            bst_in = $urandom_range(0, 3);
            e = eval(sync, sync_rst);
            sbq.push_back(e);
            @(posedge clk);
            #1;
            step(e);
        end
        rst = 0;
        en = 0;
        sync = 0;
        repeat (2) @(negedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
